// File: rtl/cpu_ctrl_seq_if.sv
// Instruction fetch port between the control sequencer (master) and instruction memory (slave).
// The address must stay stable while the request is held and no acknowledge has arrived.
interface cpu_ctrl_seq_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer in front of the general register file.
// It fetches, decodes and executes one instruction at a time and issues a single write strobe per write.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_FETCH  | imem_req high; latch instruction into ir on imem_ack
//  S_DECODE | register/memory selects driven from ir
//  S_EXEC   | result and branch condition registered
//  S_WB     | write strobe for writing ops, pc update
//  S_HALT   | terminal; only reset leaves it
module cpu_ctrl_seq #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_ctrl_seq_if.master        imem,
    output logic [3:0]            rs1,
    output logic [3:0]            rs2,
    output logic [3:0]            rd,
    output logic [5:0]            mem_addr,
    input  logic [31:0]           x_rs1_i,
    input  logic [31:0]           x_rs2_i,
    input  logic [31:0]           mem_rd_i,
    output logic                  w_en,
    output logic [31:0]           x_rd,
    output logic [31:0]           mem_val,
    output logic [PC_W-1:0]       pc,
    output logic                  halted,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_JAL  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd8;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [31:0]     res_q;
    logic [31:0]     res_d;
    logic            br_q;
    logic            illegal_q;
    logic            req_d;
    logic            wen_d;

    logic [3:0]      op;
    logic [3:0]      f_rd;
    logic [3:0]      f_rs1;
    logic [3:0]      f_rs2;
    logic [31:0]     imm32;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic            is_mem;
    logic            is_write;
    logic            is_illegal;

    assign op     = ir_q[31:28];
    assign f_rd   = ir_q[27:24];
    assign f_rs1  = ir_q[23:20];
    assign f_rs2  = ir_q[19:16];
    assign imm32  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign offset = imm32[PC_W-1:0];
    assign pc_inc = pc_q + PC_W'(1);

    assign is_mem     = (op == OP_LD) || (op == OP_ST);
    assign is_illegal = (op > OP_HALT);

    always_comb begin
        is_write = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI, OP_LD, OP_ST, OP_JAL: is_write = 1'b1;
            default:                                        is_write = 1'b0;
        endcase
    end

    // Selects come straight from ir, so they hold from DECODE until the next fetch lands.
    // A store routes rd to rs1 so the shared strobe rewrites x[rs1] with its own value.
    assign rs1      = f_rs1;
    assign rs2      = f_rs2;
    assign rd       = (op == OP_ST) ? f_rs1 : f_rd;
    assign mem_addr = is_mem ? ir_q[5:0] : 6'd0;

    always_comb begin
        res_d = 32'd0;
        case (op)
            OP_ADD:  res_d = x_rs1_i + x_rs2_i;
            OP_SUB:  res_d = x_rs1_i - x_rs2_i;
            OP_ADDI: res_d = x_rs1_i + imm32;
            OP_LD:   res_d = mem_rd_i;
            OP_ST:   res_d = x_rs1_i;
            OP_JAL:  res_d = {{(32 - PC_W){1'b0}}, pc_inc};
            default: res_d = 32'd0;
        endcase
    end

    assign pc_next = (br_q || (op == OP_JAL)) ? (pc_q + offset) : pc_inc;

    always_comb begin
        state_d = state_q;
        req_d   = 1'b0;
        wen_d   = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_d = 1'b1;
                if (imem.imem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = S_WB;
            S_WB: begin
                wen_d   = is_write;
                state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        // Reset is synchronous, but a pending write or request must not escape in the reset cycle.
        if (reset) begin
            req_d = 1'b0;
            wen_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            res_q     <= 32'd0;
            br_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_FETCH) && imem.imem_ack) begin
                ir_q <= imem.imem_data;
            end
            if ((state_q == S_DECODE) && is_illegal) begin
                illegal_q <= 1'b1;
            end
            if (state_q == S_EXEC) begin
                res_q <= res_d;
                br_q  <= (op == OP_BEQ) && (x_rs1_i == x_rs2_i);
            end
            if ((state_q == S_WB) && (op != OP_HALT)) begin
                pc_q <= pc_next;
            end
        end
    end

    assign imem.imem_req  = req_d;
    assign imem.imem_addr = pc_q;

    // Non-store writes hand the memory back its own word so the shared strobe leaves it intact.
    assign w_en    = wen_d;
    assign x_rd    = res_q;
    assign mem_val = (op == OP_ST) ? x_rs2_i : mem_rd_i;
    assign pc      = pc_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: instruction memory with per-address ack delay and a register file model.
// Each program segment starts from reset and ends in HALT.
module tb_cpu_ctrl_seq;

    logic        clk;
    logic        reset;
    logic [3:0]  rs1, rs2, rd;
    logic [5:0]  mem_addr;
    logic [31:0] x_rs1_i, x_rs2_i, mem_rd_i;
    logic        w_en;
    logic [31:0] x_rd, mem_val;
    logic [7:0]  pc;
    logic        halted, illegal;

    cpu_ctrl_seq_if #(.PC_W(8)) imem_bus ();

    cpu_ctrl_seq #(.PC_W(8), .RESET_PC(8'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .imem     (imem_bus),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .mem_addr (mem_addr),
        .x_rs1_i  (x_rs1_i),
        .x_rs2_i  (x_rs2_i),
        .mem_rd_i (mem_rd_i),
        .w_en     (w_en),
        .x_rd     (x_rd),
        .mem_val  (mem_val),
        .pc       (pc),
        .halted   (halted),
        .illegal  (illegal)
    );

    localparam logic [31:0] HALT_I = 32'h8000_0000;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel;

    logic [31:0] imem_mem [256];
    int          ack_wait [256];
    int          wait_cnt;
    logic [31:0] xr [16] = '{default: 32'd0};
    logic [31:0] dm [64] = '{default: 32'd0};
    int          wlog [$];

    logic        pre_en = 1'b0;
    logic        pre_mem = 1'b0;
    int          pre_idx = 0;
    logic [31:0] pre_val = 32'd0;

    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic [7:0]  p_addr = 8'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Instruction memory: ack arrives once the per-address wait count has elapsed.
    always_comb begin
        imem_bus.imem_data = imem_mem[imem_bus.imem_addr];
        imem_bus.imem_ack  = imem_bus.imem_req && (wait_cnt >= ack_wait[imem_bus.imem_addr]);
    end

    always @(posedge clk) begin
        if (reset || !imem_bus.imem_req || imem_bus.imem_ack) wait_cnt <= 0;
        else                                                   wait_cnt <= wait_cnt + 1;
    end

    // Register file model: combinational reads, one shared write strobe.
    always_comb begin
        x_rs1_i  = xr[rs1];
        x_rs2_i  = xr[rs2];
        mem_rd_i = dm[mem_addr];
    end

    always @(posedge clk) begin
        if (w_en) begin
            xr[rd]       <= x_rd;
            dm[mem_addr] <= mem_val;
        end else if (pre_en) begin
            if (pre_mem) dm[pre_idx[5:0]] <= pre_val;
            else         xr[pre_idx[3:0]] <= pre_val;
        end
    end

    always @(negedge clk) begin
        if (w_en) wlog.push_back(cyc);
        if (!reset && p_req && !p_ack) begin
            check_val("req_held", {31'd0, imem_bus.imem_req}, 32'd1);
            check_val("addr_stable", {24'd0, imem_bus.imem_addr}, {24'd0, p_addr});
        end
        p_req  = imem_bus.imem_req;
        p_ack  = imem_bus.imem_ack;
        p_addr = imem_bus.imem_addr;
    end

    task automatic preset(input logic is_mem, input int idx, input logic [31:0] val);
        pre_mem = is_mem;
        pre_idx = idx;
        pre_val = val;
        pre_en  = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            imem_mem[i] = 32'd0;
            ack_wait[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_pc", {24'd0, pc}, 32'd0);
        check_val("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_val("rst_wen", {31'd0, w_en}, 32'd0);
        check_val("rst_flags", {30'd0, halted, illegal}, 32'd0);
        check_val("rst_sel", {18'd0, rs1, rs2, rd, mem_addr}, 32'd0);
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        check_val({tag, "_halted"}, {31'd0, halted}, 32'd1);
    endtask

    task automatic run_prog(input string tag);
        wlog.delete();
        rel   = cyc;
        reset = 1'b0;
        wait_halt(tag);
    endtask

    task automatic check_frozen(input string tag, input logic [7:0] exp_pc);
        logic bad_req = 1'b0;
        logic bad_wen = 1'b0;
        logic bad_pc  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bad_req |= imem_bus.imem_req;
            bad_wen |= w_en;
            bad_pc  |= (pc !== exp_pc) || !halted;
        end
        check_val({tag, "_frozen"}, {29'd0, bad_req, bad_wen, bad_pc}, 32'd0);
        check_val({tag, "_pc"}, {24'd0, pc}, {24'd0, exp_pc});
    endtask

    initial begin
        reset = 1'b1;
        clear_prog();

        // A: back-to-back arithmetic with same-cycle ack.
        do_reset();
        imem_mem[0] = 32'h3100_0005;
        imem_mem[1] = 32'h3200_0007;
        imem_mem[2] = 32'h1312_0000;
        imem_mem[3] = HALT_I;
        run_prog("A");
        check_val("A_x3", xr[3], 32'd12);
        check_val("A_wen_count", wlog.size(), 32'd3);
        if (wlog.size() == 3) begin
            check_val("A_first_wen", wlog[0] - rel, 32'd3);
            check_val("A_gap1", wlog[1] - wlog[0], 32'd4);
            check_val("A_gap2", wlog[2] - wlog[1], 32'd4);
        end
        check_frozen("A", 8'd3);

        // B: stalled second fetch, then store/load through mem[10].
        do_reset();
        preset(1'b1, 0, 32'hDEAD_BEEF);
        preset(1'b0, 4, 32'h0000_0099);
        clear_prog();
        imem_mem[0] = 32'h3100_0005;
        imem_mem[1] = 32'h3200_0007;
        ack_wait[1] = 3;
        imem_mem[2] = 32'h5012_000A;
        imem_mem[3] = 32'h4400_000A;
        imem_mem[4] = HALT_I;
        run_prog("B");
        check_val("B_wen_count", wlog.size(), 32'd4);
        if (wlog.size() == 4) begin
            check_val("B_stall_gap", wlog[1] - wlog[0], 32'd7);
            check_val("B_st_gap", wlog[2] - wlog[1], 32'd4);
            check_val("B_ld_gap", wlog[3] - wlog[2], 32'd4);
        end
        check_val("B_mem10", dm[10], 32'd7);
        check_val("B_x4", xr[4], 32'd7);
        check_val("B_x2", xr[2], 32'd7);
        check_val("B_x1_kept", xr[1], 32'd5);
        check_val("B_mem0_kept", dm[0], 32'hDEAD_BEEF);

        // C: JAL to 5, BEQ taken with imm=-2 back to 3 (HALT).
        do_reset();
        preset(1'b0, 7, 32'h0000_0077);
        clear_prog();
        imem_mem[0] = 32'h7700_0005;
        imem_mem[5] = 32'h6011_FFFE;
        imem_mem[3] = HALT_I;
        run_prog("C");
        check_val("C_pc", {24'd0, pc}, 32'd3);
        check_val("C_x7", xr[7], 32'd1);
        check_val("C_wen_count", wlog.size(), 32'd1);

        // D: branch to 0xFF, JAL there wraps link and target to 0.
        do_reset();
        preset(1'b0, 5, 32'h0000_1234);
        preset(1'b0, 10, 32'h0000_1234);
        clear_prog();
        imem_mem[0]   = 32'h605A_00FF;
        imem_mem[255] = 32'h7500_0001;
        imem_mem[1]   = HALT_I;
        run_prog("D");
        check_val("D_x5", xr[5], 32'd0);
        check_val("D_x10", xr[10], 32'h0000_1234);
        check_val("D_pc", {24'd0, pc}, 32'd1);
        check_val("D_wen_count", wlog.size(), 32'd1);

        // E: illegal opcode at 0xFE, sequential wrap from 0xFF, then HALT.
        do_reset();
        preset(1'b0, 11, 32'd0);
        clear_prog();
        imem_mem[0]   = 32'h60B0_00FE;
        imem_mem[254] = 32'hC123_4567;
        imem_mem[255] = 32'h3BB0_0001;
        imem_mem[1]   = HALT_I;
        run_prog("E");
        check_val("E_illegal", {31'd0, illegal}, 32'd1);
        check_val("E_x11", xr[11], 32'd1);
        check_val("E_x1_kept", xr[1], 32'd5);
        check_val("E_wen_count", wlog.size(), 32'd1);
        check_frozen("E", 8'd1);
        check_val("E_illegal_held", {31'd0, illegal}, 32'd1);

        // F: reset lands on the WB cycle of an ADD.
        do_reset();
        preset(1'b0, 12, 32'h0000_0055);
        clear_prog();
        imem_mem[0] = 32'h1C12_0000;
        imem_mem[1] = HALT_I;
        wlog.delete();
        rel   = cyc;
        reset = 1'b0;
        while (cyc < rel + 2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("F_wb_wen", {31'd0, w_en}, 32'd0);
        check_val("F_wb_req", {31'd0, imem_bus.imem_req}, 32'd0);
        @(negedge clk);
        check_val("F_x12_kept", xr[12], 32'h0000_0055);
        check_val("F_no_pulse", wlog.size(), 32'd0);
        check_val("F_pc", {24'd0, pc}, 32'd0);
        check_val("F_illegal", {31'd0, illegal}, 32'd0);
        rel   = cyc;
        reset = 1'b0;
        #1;
        check_val("F_req_after", {31'd0, imem_bus.imem_req}, 32'd1);
        check_val("F_addr_after", {24'd0, imem_bus.imem_addr}, 32'd0);
        wait_halt("F");
        check_val("F_x12", xr[12], 32'd12);
        check_val("F_wen_count", wlog.size(), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
